// File: rtl/sweep_pair_collector_pkg.sv
// Shared definitions for the sweep pair collector and its helpers.
//
// Contents:
//   TS_W / DATA_W    : timestamp width (24) and LFSR word width (17)
//   MAX_GAP_DEFAULT  : default maximum spacing, in 96 MHz cycles, between the two words of a pair
//   POLY_A / POLY_B  : the two sweep polynomials the finder can report
//   state_e          : collector FSM state encoding
package sweep_pair_collector_pkg;

    localparam int TS_W   = 24;
    localparam int DATA_W = 17;

    localparam logic [TS_W-1:0] MAX_GAP_DEFAULT = 24'd2_000_000;

    localparam logic [DATA_W-1:0] POLY_A = 17'h1D258;
    localparam logic [DATA_W-1:0] POLY_B = 17'h17E04;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_HAVE_FIRST,
        ST_START,
        ST_BUSY,
        ST_RELEASE
    } state_e;

endpackage

// File: rtl/sweep_pair_collector_timestamp_counter.sv
// Free-running timestamp counter, shared by the sensor channels.
//
// Ports:
//   clk_i   : counting clock (96 MHz)
//   reset_i : synchronous, active-high; clears the count to zero
//   count_o : current count, advances by one per cycle and wraps 24'hFFFFFF -> 0
module timestamp_counter
    import sweep_pair_collector_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    output logic [TS_W-1:0] count_o
);

    logic [TS_W-1:0] count_q;

    // Plain binary counter; the wrap at the top is the natural overflow of the
    // register, which is what makes modulo-2^24 elapsed-time arithmetic work downstream.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sweep_pair_collector.sv
// Pairs consecutive decoded LFSR words, timestamps them against a 96 MHz counter,
// hands each pair to polynomial_finder and republishes its answer with a strobe.
//
// Ports:
//   clk_96MHz, reset                 : sole clock, synchronous active-high reset
//   data_in, data_in_valid           : decoded 17-bit word and its one-cycle strobe
//   decoded_data, ts_last_data       : first word of the pair and its timestamp (to finder)
//   decoded_data1, ts_last_data1     : second word of the pair and its timestamp (to finder)
//   finder_enable, finder_ready      : enable/ready handshake with the finder
//   finder_polynomial/iteration      : finder results
//   result_valid                     : one-cycle strobe for the angle stage
//   result_polynomial/iteration/ts   : latched finder results and first-word timestamp
//   drop_count                       : words dropped while a pair is in flight (optional)
//
// Optional build macro: SWEEP_PAIR_COLLECTOR_DROP_COUNT_EN adds the saturating
// drop_count port; without it dropped words are discarded silently.
module sweep_pair_collector
    import sweep_pair_collector_pkg::*;
#(
    parameter logic [TS_W-1:0] MAX_GAP = MAX_GAP_DEFAULT
) (
    input  logic              clk_96MHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic [TS_W-1:0]   ts_last_data,
    output logic [TS_W-1:0]   ts_last_data1,
    output logic [DATA_W-1:0] decoded_data,
    output logic [DATA_W-1:0] decoded_data1,
    output logic              finder_enable,
    input  logic              finder_ready,
    input  logic [DATA_W-1:0] finder_polynomial,
    input  logic [DATA_W-1:0] finder_iteration,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_polynomial,
    output logic [DATA_W-1:0] result_iteration,
    output logic [TS_W-1:0]   result_ts
`ifdef SWEEP_PAIR_COLLECTOR_DROP_COUNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    logic [TS_W-1:0]   ts_now;
    logic [TS_W-1:0]   elapsed;
    logic              gap_ok;

    state_e            state_q;
    logic [DATA_W-1:0] data_first_q;
    logic [DATA_W-1:0] data_second_q;
    logic [TS_W-1:0]   ts_first_q;
    logic [TS_W-1:0]   ts_second_q;
    logic              enable_q;
    logic              accepted_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_poly_q;
    logic [DATA_W-1:0] res_iter_q;
    logic [TS_W-1:0]   res_ts_q;

    timestamp_counter u_ts_counter (
        .clk_i   (clk_96MHz),
        .reset_i (reset),
        .count_o (ts_now)
    );

    // Unsigned subtraction in 24 bits gives the elapsed time across the counter wrap.
    assign elapsed = ts_now - ts_first_q;
    assign gap_ok  = (elapsed <= MAX_GAP);

    // Pairing and finder handshake FSM. In START the enable stays low until the
    // finder reports ready, so a finder still finishing an aborted run completes
    // first. In BUSY we must see ready fall (accepted) before a rising ready
    // counts as done. Words arriving in START/BUSY/RELEASE are simply not latched.
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state_q       <= ST_EMPTY;
            data_first_q  <= '0;
            data_second_q <= '0;
            ts_first_q    <= '0;
            ts_second_q   <= '0;
            enable_q      <= 1'b0;
            accepted_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_poly_q    <= '0;
            res_iter_q    <= '0;
            res_ts_q      <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    if (data_in_valid) begin
                        data_first_q <= data_in;
                        ts_first_q   <= ts_now;
                        state_q      <= ST_HAVE_FIRST;
                    end
                end
                ST_HAVE_FIRST: begin
                    if (data_in_valid) begin
                        if (gap_ok) begin
                            data_second_q <= data_in;
                            ts_second_q   <= ts_now;
                            state_q       <= ST_START;
                        end else begin
                            data_first_q <= data_in;
                            ts_first_q   <= ts_now;
                        end
                    end else if (!gap_ok) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_START: begin
                    if (finder_ready) begin
                        enable_q   <= 1'b1;
                        accepted_q <= 1'b0;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!finder_ready) begin
                        accepted_q <= 1'b1;
                    end else if (accepted_q) begin
                        res_poly_q  <= finder_polynomial;
                        res_iter_q  <= finder_iteration;
                        res_ts_q    <= ts_first_q;
                        res_valid_q <= 1'b1;
                        enable_q    <= 1'b0;
                        state_q     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_EMPTY;
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef SWEEP_PAIR_COLLECTOR_DROP_COUNT_EN
    logic       word_dropped;
    logic [7:0] drop_count_q;
    logic [7:0] drop_count_d;

    assign word_dropped = data_in_valid &&
                          ((state_q == ST_START) || (state_q == ST_BUSY) || (state_q == ST_RELEASE));

    // Saturating count of words discarded while a pair is in flight.
    always_comb begin
        drop_count_d = drop_count_q;
        if (word_dropped && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign decoded_data      = data_first_q;
    assign decoded_data1     = data_second_q;
    assign ts_last_data      = ts_first_q;
    assign ts_last_data1     = ts_second_q;
    assign finder_enable     = enable_q;
    assign result_valid      = res_valid_q;
    assign result_polynomial = res_poly_q;
    assign result_iteration  = res_iter_q;
    assign result_ts         = res_ts_q;

endmodule

// File: tb/tb_sweep_pair_collector.sv
// Directed bench for sweep_pair_collector with a behavioural polynomial_finder.
// MAX_GAP is shortened to 1500 cycles so gap cases finish quickly.
module tb_sweep_pair_collector;
    import sweep_pair_collector_pkg::*;

    localparam logic [23:0] TB_MAX_GAP = 24'd1500;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] dataIn = '0;
    logic        dataInValid = 1'b0;
    logic [23:0] tsLastData;
    logic [23:0] tsLastData1;
    logic [16:0] decodedData;
    logic [16:0] decodedData1;
    logic        finderEnable;
    logic        finderReady = 1'b1;
    logic [16:0] finderPoly = '0;
    logic [16:0] finderIter = '0;
    logic        resultValid;
    logic [16:0] resultPoly;
    logic [16:0] resultIter;
    logic [23:0] resultTs;
`ifdef SWEEP_PAIR_COLLECTOR_DROP_COUNT_EN
    logic [7:0]  dropCount;
`endif

    int          checkCount = 0;
    int          failCount = 0;
    int          tbCycle = 0;
    int          cycleOrigin = 0;
    logic [23:0] tsOrigin = '0;

    int          modelLatency = 40;
    logic [16:0] modelPoly = '0;
    logic [16:0] modelIter = '0;
    int          busyCnt = 0;

    logic        enPrev = 1'b0;
    int          enableRises = 0;
    int          validPulses = 0;

    sweep_pair_collector #(.MAX_GAP(TB_MAX_GAP)) dut (
        .clk_96MHz         (clk),
        .reset             (reset),
        .data_in           (dataIn),
        .data_in_valid     (dataInValid),
        .ts_last_data      (tsLastData),
        .ts_last_data1     (tsLastData1),
        .decoded_data      (decodedData),
        .decoded_data1     (decodedData1),
        .finder_enable     (finderEnable),
        .finder_ready      (finderReady),
        .finder_polynomial (finderPoly),
        .finder_iteration  (finderIter),
        .result_valid      (resultValid),
        .result_polynomial (resultPoly),
        .result_iteration  (resultIter),
`ifdef SWEEP_PAIR_COLLECTOR_DROP_COUNT_EN
        .drop_count        (dropCount),
`endif
        .result_ts         (resultTs)
    );

    // 96 MHz stand-in clock; only the edge ordering matters here.
    always #5 clk = ~clk;

    // Cycle tally used to predict the DUT's free-running timestamp.
    always @(posedge clk) begin
        tbCycle <= tbCycle + 1;
    end

    // Counts rising edges of finder_enable and cycles with result_valid high.
    always @(posedge clk) begin
        enPrev <= finderEnable;
        if (finderEnable && !enPrev) enableRises <= enableRises + 1;
        if (resultValid) validPulses <= validPulses + 1;
    end

    // Behavioural finder: accepts on enable by dropping ready, stays busy for
    // modelLatency cycles, then raises ready with the programmed result. It ignores
    // the collector's reset, so a run in progress always completes.
    always @(negedge clk) begin
        if (busyCnt > 1) begin
            busyCnt <= busyCnt - 1;
        end else if (busyCnt == 1) begin
            busyCnt     <= 0;
            finderReady <= 1'b1;
            finderPoly  <= modelPoly;
            finderIter  <= modelIter;
        end else if (finderEnable && finderReady) begin
            finderReady <= 1'b0;
            busyCnt     <= modelLatency;
        end
    end

    function automatic logic [23:0] expectTs();
        return 24'(tsOrigin + 24'(tbCycle - cycleOrigin));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one word for one cycle starting at a negedge; returns its expected stamp.
    task automatic applyStimulus(input logic [16:0] word, output logic [23:0] ts);
        dataIn      = word;
        dataInValid = 1'b1;
        ts          = expectTs();
        @(negedge clk);
        dataInValid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitEnable(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (finderEnable) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic waitResult(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (resultValid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [23:0] tsA, tsB, tsX, tsDiff;
        bit          seen;
        bit          enEarly;
        int          vb, eb, guard;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_finder_enable", 32'(finderEnable), 0);
        checkOutput("reset_result_valid", 32'(resultValid), 0);
        checkOutput("reset_decoded_data", 32'(decodedData), 0);
        checkOutput("reset_ts_last_data1", 32'(tsLastData1), 0);
        checkOutput("reset_result_poly", 32'(resultPoly), 0);
        checkOutput("reset_result_ts", 32'(resultTs), 0);
        reset       = 1'b0;
        tsOrigin    = '0;
        cycleOrigin = tbCycle;
        idleCycles(5);

        // Basic pair 1000 cycles apart, three words dropped while busy
        modelPoly = POLY_A; modelIter = 17'd62; modelLatency = 40;
        applyStimulus(17'h00123, tsA);
        idleCycles(999);
        applyStimulus(17'h04567, tsB);
        tsDiff = tsLastData1 - tsLastData;
        checkOutput("p1_enable_low_in_start", 32'(finderEnable), 0);
        checkOutput("p1_decoded_data", 32'(decodedData), 32'h00123);
        checkOutput("p1_decoded_data1", 32'(decodedData1), 32'h04567);
        checkOutput("p1_ts_first", 32'(tsLastData), 32'(tsA));
        checkOutput("p1_ts_second", 32'(tsLastData1), 32'(tsB));
        checkOutput("p1_ts_diff", 32'(tsDiff), 1000);
        @(negedge clk);
        checkOutput("p1_enable_after_one", 32'(finderEnable), 1);
        vb = validPulses;
        applyStimulus(17'h1FFFF, tsX);
        applyStimulus(17'h0ABCD, tsX);
        applyStimulus(17'h00001, tsX);
        checkOutput("p1_drop_keeps_first", 32'(decodedData), 32'h00123);
        checkOutput("p1_drop_keeps_second", 32'(decodedData1), 32'h04567);
        checkOutput("p1_drop_keeps_ts", 32'(tsLastData1), 32'(tsB));
`ifdef SWEEP_PAIR_COLLECTOR_DROP_COUNT_EN
        checkOutput("p1_drop_count", 32'(dropCount), 3);
`endif
        waitResult(200, seen);
        checkOutput("p1_result_seen", 32'(seen), 1);
        checkOutput("p1_result_poly", 32'(resultPoly), 32'h1D258);
        checkOutput("p1_result_iter", 32'(resultIter), 62);
        checkOutput("p1_result_ts", 32'(resultTs), 32'(tsA));
        checkOutput("p1_enable_low_at_result", 32'(finderEnable), 0);
        idleCycles(3);
        checkOutput("p1_single_pulse", 32'(validPulses - vb), 1);

        // Counter wrap between the two words
        modelPoly = POLY_B; modelIter = 17'd5;
        force dut.u_ts_counter.count_q = 24'hFFFF00;
        release dut.u_ts_counter.count_q;
        tsOrigin    = 24'hFFFF00;
        cycleOrigin = tbCycle;
        applyStimulus(17'h0AAAA, tsA);
        idleCycles(511);
        applyStimulus(17'h15555, tsB);
        checkOutput("wrap_ts_first", 32'(tsLastData), 32'hFFFF00);
        checkOutput("wrap_ts_second", 32'(tsLastData1), 32'h000100);
        waitResult(200, seen);
        checkOutput("wrap_result_seen", 32'(seen), 1);
        checkOutput("wrap_result_poly", 32'(resultPoly), 32'h17E04);
        checkOutput("wrap_result_ts", 32'(resultTs), 32'hFFFF00);
        idleCycles(3);

        // Second word one cycle beyond MAX_GAP restarts the pair
        modelPoly = POLY_A; modelIter = 17'd7;
        eb = enableRises;
        applyStimulus(17'h00A01, tsX);
        idleCycles(1500);
        applyStimulus(17'h00A02, tsA);
        idleCycles(99);
        checkOutput("gap_no_enable", 32'(enableRises - eb), 0);
        checkOutput("gap_new_first", 32'(decodedData), 32'h00A02);
        checkOutput("gap_new_first_ts", 32'(tsLastData), 32'(tsA));
        applyStimulus(17'h00A03, tsB);
        checkOutput("gap_second", 32'(decodedData1), 32'h00A03);
        checkOutput("gap_second_ts", 32'(tsLastData1), 32'(tsB));
        waitResult(200, seen);
        checkOutput("gap_result_seen", 32'(seen), 1);
        checkOutput("gap_result_ts", 32'(resultTs), 32'(tsA));
        idleCycles(3);

        // Exactly MAX_GAP apart still pairs
        applyStimulus(17'h00B01, tsA);
        idleCycles(1499);
        applyStimulus(17'h00B02, tsB);
        tsDiff = tsLastData1 - tsLastData;
        checkOutput("edge_second", 32'(decodedData1), 32'h00B02);
        checkOutput("edge_ts_diff", 32'(tsDiff), 1500);
        waitEnable(10, seen);
        checkOutput("edge_enable", 32'(seen), 1);
        waitResult(200, seen);
        checkOutput("edge_result_seen", 32'(seen), 1);
        idleCycles(3);

        // Identical words: finder reports no match, result still strobed
        modelPoly = '0; modelIter = '0;
        applyStimulus(17'h03333, tsA);
        idleCycles(199);
        applyStimulus(17'h03333, tsB);
        tsDiff = tsLastData1 - tsLastData;
        checkOutput("same_ts_diff", 32'(tsDiff), 200);
        waitResult(200, seen);
        checkOutput("same_result_seen", 32'(seen), 1);
        checkOutput("same_result_poly", 32'(resultPoly), 0);
        checkOutput("same_result_ts", 32'(resultTs), 32'(tsA));
        idleCycles(3);

`ifdef SWEEP_PAIR_COLLECTOR_DROP_COUNT_EN
        // Drop counter saturation with a long finder run
        modelLatency = 700;
        applyStimulus(17'h00C01, tsA);
        idleCycles(9);
        applyStimulus(17'h00C02, tsB);
        waitEnable(10, seen);
        checkOutput("sat_enable", 32'(seen), 1);
        dataIn      = 17'h12345;
        dataInValid = 1'b1;
        idleCycles(300);
        dataInValid = 1'b0;
        @(negedge clk);
        checkOutput("sat_drop_count", 32'(dropCount), 255);
        waitResult(800, seen);
        checkOutput("sat_result_seen", 32'(seen), 1);
        idleCycles(3);
`endif

        // Reset while the finder is busy
        modelLatency = 200; modelPoly = POLY_B; modelIter = 17'd9;
        applyStimulus(17'h00D01, tsA);
        idleCycles(9);
        applyStimulus(17'h00D02, tsB);
        waitEnable(10, seen);
        checkOutput("rst_enable_before", 32'(seen), 1);
        idleCycles(5);
        vb    = validPulses;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_enable_dropped", 32'(finderEnable), 0);
        checkOutput("rst_no_valid", 32'(resultValid), 0);
        checkOutput("rst_pair_cleared", 32'(decodedData1), 0);
        reset        = 1'b0;
        tsOrigin     = '0;
        cycleOrigin  = tbCycle;
        modelLatency = 20;
        applyStimulus(17'h00E01, tsA);
        idleCycles(9);
        applyStimulus(17'h00E02, tsB);
        enEarly = 1'b0;
        guard   = 0;
        while (!finderReady && guard < 400) begin
            if (finderEnable) enEarly = 1'b1;
            @(negedge clk);
            guard++;
        end
        checkOutput("rst_enable_withheld", 32'(enEarly), 0);
        checkOutput("rst_model_recovered", 32'(finderReady), 1);
        waitEnable(10, seen);
        checkOutput("rst_enable_after_ready", 32'(seen), 1);
        waitResult(200, seen);
        checkOutput("rst_result_seen", 32'(seen), 1);
        checkOutput("rst_result_poly", 32'(resultPoly), 32'h17E04);
        checkOutput("rst_result_ts", 32'(resultTs), 32'(tsA));
        idleCycles(3);
        checkOutput("rst_one_result_only", 32'(validPulses - vb), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/sweep_pair_collector.md
# sweep_pair_collector

Front end of the polynomial identification path. Timestamps each 17-bit LFSR word delivered by the BMC decoder against a free-running 24-bit 96 MHz counter and pairs consecutive words. It hands each pair to `polynomial_finder` over its `enable`/`ready` handshake, then republishes the finder's `polynomial`/`iteration_number` with a one-cycle valid strobe for the angle-computation stage.

## Interface
Parameters:
- `MAX_GAP`, default 24'd2_000_000: maximum clock cycles between the two words of a pair; an older first word is discarded.

Ports:
- `clk_96MHz` input 1: sole clock.
- `reset` input 1: synchronous, active-high.
- `data_in` input 17: decoded LFSR word from the decoder.
- `data_in_valid` input 1: one-cycle strobe; `data_in` is valid while high.
- `ts_last_data` output 24: timestamp of the first word of the pair (to finder).
- `ts_last_data1` output 24: timestamp of the second word (to finder).
- `decoded_data` output 17: first word (to finder).
- `decoded_data1` output 17: second word (to finder).
- `finder_enable` output 1: drives finder `enable`.
- `finder_ready` input 1: finder `ready`.
- `finder_polynomial` input 17, `finder_iteration` input 17: finder results.
- `result_valid` output 1: one-cycle strobe.
- `result_polynomial` output 17: 0 means no match.
- `result_iteration` output 17.
- `result_ts` output 24: timestamp of the first word of the matched pair.
- `drop_count` output 8: present only with `SWEEP_PAIR_COLLECTOR_DROP_COUNT_EN`.

## Operation
- Timestamp counter: 24-bit, +1 every cycle, wraps 24'hFFFFFF→0. A word's timestamp is the counter value in the cycle `data_in_valid` is high.
- States: EMPTY, HAVE_FIRST, START, BUSY, RELEASE.
- EMPTY: on `data_in_valid`, latch the word/timestamp into the `decoded_data`/`ts_last_data` registers and go to HAVE_FIRST.
- HAVE_FIRST, elapsed cycles computed modulo 2^24:
  - `data_in_valid` with elapsed ≤ MAX_GAP: latch `decoded_data1`/`ts_last_data1` and go to START.
  - `data_in_valid` with elapsed > MAX_GAP: the new word replaces the first; stay in HAVE_FIRST.
  - No word and elapsed > MAX_GAP: go to EMPTY.
- START: wait for `finder_ready`=1 with `finder_enable` low, so a finder still completing an aborted run is allowed to finish. Then assert `finder_enable` and go to BUSY.
- BUSY: hold `finder_enable`=1.
  - Wait for `finder_ready`=0 (accept), then `finder_ready`=1 (done).
  - On done, copy the finder results and `ts_last_data` into the result registers, pulse `result_valid`, drop `finder_enable`, and go to RELEASE.
- RELEASE: one cycle, then EMPTY.
- Words arriving in START/BUSY/RELEASE are dropped and do not disturb the pair presented to the finder.
- Equal words or equal timestamps are forwarded unchanged. The finder reports these as polynomial 0, and the collector still emits `result_valid`.

## Timing
- Reset values: all outputs 0, counter 0, state EMPTY. Reset mid-BUSY drops `finder_enable` in the next cycle; no `result_valid`.
- `finder_enable` rises ≥1 cycle after the second word is captured (exactly 1 if `finder_ready` is already 1).
- `result_valid` is high in the cycle after `finder_ready` is sampled rising in BUSY. `finder_enable` is low in that same cycle.
- Pair-to-pair minimum: RELEASE plus a new first word; there is no word chaining.
- A word in the same cycle the MAX_GAP timeout fires is treated as a new first word.

## Configuration
- `SWEEP_PAIR_COLLECTOR_DROP_COUNT_EN` defined:
  - `drop_count` port exists.
  - It increments by one per word dropped in START/BUSY/RELEASE and saturates at 8'hFF.
  - Reset clears it.
- Undefined: the port and counter are absent. Drops are silent.

## Structure
- Shared package:
  - state encoding;
  - timestamp width (24) and data width (17);
  - `MAX_GAP` default;
  - polynomial constants 17'h1D258 / 17'h17E04, for bench checking.
- Sub-module `timestamp_counter`: 24-bit wrapping counter with synchronous reset. It is shared with other sensor channels.

## Test plan
- Words 17'h00123 then 17'h04567 are 1000 cycles apart, with a finder model that returns ready after 40 cycles, polynomial 17'h1D258, iteration 62 → ts difference = 1000, one `result_valid` with 17'h1D258/62, `result_ts` equal to the first stamp.
- First word at counter 24'hFFFF00, second 512 cycles later → `ts_last_data1` = 24'h000100, pair forwarded (wrap handled).
- Second word MAX_GAP+1 cycles after the first → no `finder_enable`; the second word becomes the first; a third word 100 cycles later forms the pair.
- 3 words sent during BUSY → pair unchanged and one result. With the macro defined, `drop_count`=3; 300 drops → 255.
- `reset` asserted in BUSY with the finder model still busy → `finder_enable` low next cycle, no `result_valid`. The next pair's enable is withheld until the model's ready returns to 1.
- Two identical words 200 cycles apart, finder returns polynomial 0 → `result_valid` with `result_polynomial`=0.
